// File: rtl/grid_frame_streamer_if.sv
// Valid/ready sample stream from the grid frame streamer to the network input stage.
// master drives the samples and the slave drives out_ready.
interface grid_frame_streamer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [ADDR_W-1:0] out_index;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/grid_frame_streamer.sv
// Reads the 28x28 one-bit drawing grid in row-major order and streams each cell as
// an 8-bit intensity sample. It also counts the set cells of each frame for debug.
module grid_frame_streamer #(
  parameter int                GRID_SIZE = 28,
  parameter int                PIXELS    = GRID_SIZE * GRID_SIZE,
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] ON_VALUE  = 8'd255
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_rd_data,
  grid_frame_streamer_if.master stream,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    pixel_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] index_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] out_index_reg;
  logic [ADDR_W-1:0] count_reg;
  logic              abort_hit;
  logic              xfer;

  assign abort_hit = abort && (state_reg != S_IDLE);
  assign xfer      = valid_reg && stream.out_ready;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort outranks everything, including a transfer on the same edge
  always_comb begin
    state_next = state_reg;
    if (abort_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start) state_next = S_READ;
        S_READ:  state_next = S_LATCH;
        S_LATCH: state_next = S_SEND;
        S_SEND: begin
          if (xfer) state_next = (index_reg == LAST_IDX) ? S_DONE : S_READ;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // the address is live only during READ so the memory sees a stable index elsewhere
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_addr = addr_hold_reg;
    case (state_reg)
      S_IDLE:  busy = 1'b0;
      S_READ: begin
        busy     = 1'b1;
        mem_addr = index_reg;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      index_reg     <= '0;
      addr_hold_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      out_index_reg <= '0;
      count_reg     <= '0;
    end else if (abort_hit) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            index_reg <= '0;
            count_reg <= '0;
          end
        end
        S_READ: addr_hold_reg <= index_reg;
        S_LATCH: begin
          data_reg      <= mem_rd_data ? ON_VALUE : '0;
          valid_reg     <= 1'b1;
          out_index_reg <= index_reg;
          last_reg      <= (index_reg == LAST_IDX);
          count_reg     <= count_reg + ADDR_W'(mem_rd_data);
        end
        S_SEND: begin
          if (xfer) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            if (index_reg != LAST_IDX) index_reg <= index_reg + ADDR_W'(1);
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  assign stream.out_data  = data_reg;
  assign stream.out_valid = valid_reg;
  assign stream.out_last  = last_reg;
  assign stream.out_index = out_index_reg;
  assign pixel_count      = count_reg;

endmodule
